// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arb_pkg
//  Description : Shared definitions for the instruction/data memory arbiter:
//                FSM state encoding, default timing parameters and a small
//                state-decode helper.
//  Revision    : 1.0  initial release
// ============================================================================
package mem_arb_pkg;

   // Cycles spent waiting for mem_done before an access is abandoned.
   localparam int c_TIMEOUT_DEFAULT  = 15;
   // Consecutive data grants tolerated while a fetch is waiting.
   localparam int c_FAIR_MAX_DEFAULT = 3;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_IBUSY = 2'd1,
      ST_DBUSY = 2'd2,
      ST_RESP  = 2'd3
   } arbState_t;

   // True while an access is outstanding on the memory port.
   function automatic logic isBusy(input arbState_t state);
      return (state == ST_IBUSY) || (state == ST_DBUSY);
   endfunction

endpackage : mem_arb_pkg
`default_nettype wire

// File: rtl/arb_timer.sv
`default_nettype none
// ============================================================================
//  Module      : arb_timer
//  Description : Access watchdog. Counts cycles while enabled and flags the
//                cycle in which the TIMEOUT-th busy cycle completes.
//  Ports       : clk, rst     - clock / async active-high reset
//                clr          - restart count (asserted on access grant)
//                en           - count this cycle (access outstanding)
//                expired      - this is the last allowed busy cycle
//  Revision    : 1.0  initial release
// ============================================================================
module arb_timer
   import mem_arb_pkg::*;
#(
   parameter int TIMEOUT = c_TIMEOUT_DEFAULT
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam int c_W = $clog2(TIMEOUT + 1);
   localparam logic [c_W-1:0] c_LAST = c_W'(TIMEOUT - 1);
   localparam logic [c_W-1:0] c_SAT  = c_W'(TIMEOUT);

   logic [c_W-1:0] r_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (clr) begin
         r_cnt <= '0;
      end else if (en && (r_cnt != c_SAT)) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   // The count reaches TIMEOUT on the edge that closes this cycle.
   assign expired = en & ~clr & (r_cnt == c_LAST);

endmodule : arb_timer
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter
//  Description : Arbitrates one shared memory port between an instruction
//                fetch requester and a data (load/store) requester. Data has
//                priority, bounded by a fairness counter so a waiting fetch
//                is served after FAIR_MAX consecutive data grants. Accesses
//                that never complete are aborted by a watchdog and recorded
//                in a sticky err flag.
//  Ports       : clk, rst                      - clock / async reset
//                if_req, if_addr               - fetch request
//                d_en, d_wr, d_addr, d_wdata   - data request
//                mem_rd, mem_wr, mem_addr,
//                mem_wdata                     - memory strobes / payload
//                mem_done, mem_rdata           - memory completion / data
//                if_done, if_rdata             - fetch response
//                d_done, d_rdata               - data response
//                if_stall, d_stall             - hold requester pipelines
//                err                           - sticky timeout flag
//  Revision    : 1.0  initial release
// ============================================================================
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int TIMEOUT  = c_TIMEOUT_DEFAULT,
   parameter int FAIR_MAX = c_FAIR_MAX_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        if_req,
   input  logic [15:0] if_addr,
   input  logic        d_en,
   input  logic        d_wr,
   input  logic [15:0] d_addr,
   input  logic [15:0] d_wdata,
   output logic        mem_rd,
   output logic        mem_wr,
   output logic [15:0] mem_addr,
   output logic [15:0] mem_wdata,
   input  logic        mem_done,
   input  logic [15:0] mem_rdata,
   output logic        if_done,
   output logic [15:0] if_rdata,
   output logic        d_done,
   output logic [15:0] d_rdata,
   output logic        if_stall,
   output logic        d_stall,
   output logic        err
);

   localparam int c_FW = $clog2(FAIR_MAX + 1);
   localparam logic [c_FW-1:0] c_FAIR_TOP = c_FW'(FAIR_MAX);

   arbState_t        r_state;
   logic [c_FW-1:0]  r_fairCnt;
   logic [15:0]      r_addr;
   logic [15:0]      r_wdata;
   logic             r_memRd;
   logic             r_memWr;
   logic             r_ifDone;
   logic             r_dDone;
   logic [15:0]      r_ifRdata;
   logic [15:0]      r_dRdata;
   logic             r_err;

   logic             w_inIdle;
   logic             w_grantFetch;
   logic             w_grantData;
   logic             w_timerClr;
   logic             w_timerEn;
   logic             w_expired;

   // Data normally wins; a waiting fetch takes over once data has had
   // FAIR_MAX back-to-back grants.
   assign w_inIdle     = (r_state == ST_IDLE);
   assign w_grantFetch = w_inIdle & if_req & ((r_fairCnt == c_FAIR_TOP) | ~d_en);
   assign w_grantData  = w_inIdle & d_en & ~w_grantFetch;

   assign w_timerClr   = w_grantFetch | w_grantData;
   assign w_timerEn    = isBusy(r_state);

   arb_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_timer (
      .clk     (clk),
      .rst     (rst),
      .clr     (w_timerClr),
      .en      (w_timerEn),
      .expired (w_expired)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= ST_IDLE;
         r_fairCnt <= '0;
         r_addr    <= '0;
         r_wdata   <= '0;
         r_memRd   <= 1'b0;
         r_memWr   <= 1'b0;
         r_ifDone  <= 1'b0;
         r_dDone   <= 1'b0;
         r_ifRdata <= '0;
         r_dRdata  <= '0;
         r_err     <= 1'b0;
      end else begin
         r_ifDone <= 1'b0;
         r_dDone  <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_grantFetch) begin
                  r_state   <= ST_IBUSY;
                  r_addr    <= if_addr;
                  r_wdata   <= '0;
                  r_memRd   <= 1'b1;
                  r_memWr   <= 1'b0;
                  r_fairCnt <= '0;
               end else if (w_grantData) begin
                  r_state <= ST_DBUSY;
                  r_addr  <= d_addr;
                  r_wdata <= d_wdata;
                  r_memRd <= ~d_wr;
                  r_memWr <= d_wr;
                  // Only data grants that bypass a waiting fetch count.
                  if (if_req && (r_fairCnt != c_FAIR_TOP)) begin
                     r_fairCnt <= r_fairCnt + 1'b1;
                  end
               end
            end

            ST_IBUSY, ST_DBUSY: begin
               // Completion is checked first so it beats a coincident timeout.
               if (mem_done) begin
                  r_state <= ST_RESP;
                  r_memRd <= 1'b0;
                  r_memWr <= 1'b0;
                  if (r_state == ST_IBUSY) begin
                     r_ifDone  <= 1'b1;
                     r_ifRdata <= mem_rdata;
                  end else begin
                     r_dDone  <= 1'b1;
                     r_dRdata <= mem_rdata;
                  end
               end else if (w_expired) begin
                  r_state <= ST_IDLE;
                  r_memRd <= 1'b0;
                  r_memWr <= 1'b0;
                  r_err   <= 1'b1;
               end
            end

            ST_RESP: begin
               r_state <= ST_IDLE;
            end

            default: begin
               r_state <= ST_IDLE;
               r_memRd <= 1'b0;
               r_memWr <= 1'b0;
            end
         endcase
      end
   end

   assign mem_rd    = r_memRd;
   assign mem_wr    = r_memWr;
   assign mem_addr  = r_addr;
   assign mem_wdata = r_wdata;
   assign if_done   = r_ifDone;
   assign if_rdata  = r_ifRdata;
   assign d_done    = r_dDone;
   assign d_rdata   = r_dRdata;
   assign err       = r_err;

   assign if_stall  = if_req & ~r_ifDone;
   assign d_stall   = d_en & ~r_dDone;

endmodule : mem_arbiter
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_arbiter
//  Description : Self-checking bench for mem_arbiter: a cycle table of
//                inputs and hand-derived outputs, followed by sequences for
//                fairness, timeout, timeout/completion race and reset abort.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mem_arbiter;

   logic        clk;
   logic        rst;
   logic        if_req;
   logic [15:0] if_addr;
   logic        d_en;
   logic        d_wr;
   logic [15:0] d_addr;
   logic [15:0] d_wdata;
   logic        mem_rd;
   logic        mem_wr;
   logic [15:0] mem_addr;
   logic [15:0] mem_wdata;
   logic        mem_done;
   logic [15:0] mem_rdata;
   logic        if_done;
   logic [15:0] if_rdata;
   logic        d_done;
   logic [15:0] d_rdata;
   logic        if_stall;
   logic        d_stall;
   logic        err;

   logic        memDoneDrv;
   logic        autoResp;

   int checks = 0;
   int errors = 0;

   // Zero-latency memory model when autoResp is set.
   assign mem_done = autoResp ? (mem_rd | mem_wr) : memDoneDrv;

   mem_arbiter dut (
      .clk       (clk),
      .rst       (rst),
      .if_req    (if_req),
      .if_addr   (if_addr),
      .d_en      (d_en),
      .d_wr      (d_wr),
      .d_addr    (d_addr),
      .d_wdata   (d_wdata),
      .mem_rd    (mem_rd),
      .mem_wr    (mem_wr),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_done  (mem_done),
      .mem_rdata (mem_rdata),
      .if_done   (if_done),
      .if_rdata  (if_rdata),
      .d_done    (d_done),
      .d_rdata   (d_rdata),
      .if_stall  (if_stall),
      .d_stall   (d_stall),
      .err       (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        ifReq;
      logic [15:0] ifAddr;
      logic        dEn;
      logic        dWr;
      logic [15:0] dAddr;
      logic [15:0] dWdata;
      logic        memDone;
      logic [15:0] memRdata;
      logic        eMemRd;
      logic        eMemWr;
      logic [15:0] eMemAddr;
      logic [15:0] eMemWdata;
      logic        eIfDone;
      logic        eDDone;
      logic [15:0] eIfRdata;
      logic [15:0] eDRdata;
      logic        eIfStall;
      logic        eDStall;
      logic        eErr;
   } vec_t;

   localparam int c_NVEC = 12;
   vec_t vecs [c_NVEC];

   task automatic chk1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic vec_t mkV(
      input logic ifReq, input logic [15:0] ifAddr, input logic dEn, input logic dWr,
      input logic [15:0] dAddr, input logic [15:0] dWdata, input logic memDone,
      input logic [15:0] memRdata,
      input logic eRd, input logic eWr, input logic [15:0] eAddr, input logic [15:0] eWdata,
      input logic eIfDone, input logic eDDone, input logic [15:0] eIfRdata,
      input logic [15:0] eDRdata, input logic eIfStall, input logic eDStall, input logic eErr);
      vec_t v;
      v.ifReq = ifReq;   v.ifAddr = ifAddr;   v.dEn = dEn;       v.dWr = dWr;
      v.dAddr = dAddr;   v.dWdata = dWdata;   v.memDone = memDone; v.memRdata = memRdata;
      v.eMemRd = eRd;    v.eMemWr = eWr;      v.eMemAddr = eAddr;  v.eMemWdata = eWdata;
      v.eIfDone = eIfDone; v.eDDone = eDDone; v.eIfRdata = eIfRdata; v.eDRdata = eDRdata;
      v.eIfStall = eIfStall; v.eDStall = eDStall; v.eErr = eErr;
      return v;
   endfunction

   logic [15:0] grantLog [8];
   int          nGrant;
   int          nDDone;
   int          busy;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      // Fetch, then simultaneous fetch+store, then the delayed fetch.
      // ifReq ifAddr  dEn dWr dAddr     dWdata    mD   mRdata  | rd wr addr      wdata     ifD dD ifRdata   dRdata  ifS dS err
      vecs[0]  = mkV(1, 16'h0010, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000, 1, 0, 0);
      vecs[1]  = mkV(1, 16'h0010, 0, 0, 16'h0000, 16'h0000, 1, 16'hA5A5, 1, 0, 16'h0010, 16'h0000, 0, 0, 16'h0000, 16'h0000, 1, 0, 0);
      vecs[2]  = mkV(1, 16'h0010, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0, 16'h0010, 16'h0000, 1, 0, 16'hA5A5, 16'h0000, 0, 0, 0);
      vecs[3]  = mkV(0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 1, 16'hDEAD, 0, 0, 16'h0010, 16'h0000, 0, 0, 16'hA5A5, 16'h0000, 0, 0, 0);
      vecs[4]  = mkV(1, 16'h0020, 1, 1, 16'h0200, 16'h1234, 0, 16'h0000, 0, 0, 16'h0010, 16'h0000, 0, 0, 16'hA5A5, 16'h0000, 1, 1, 0);
      vecs[5]  = mkV(1, 16'h0020, 1, 1, 16'h0300, 16'hFFFF, 0, 16'h0000, 0, 1, 16'h0200, 16'h1234, 0, 0, 16'hA5A5, 16'h0000, 1, 1, 0);
      vecs[6]  = mkV(1, 16'h0020, 1, 1, 16'h0300, 16'hFFFF, 1, 16'h0000, 0, 1, 16'h0200, 16'h1234, 0, 0, 16'hA5A5, 16'h0000, 1, 1, 0);
      vecs[7]  = mkV(1, 16'h0020, 1, 1, 16'h0300, 16'hFFFF, 1, 16'hBEEF, 0, 0, 16'h0200, 16'h1234, 0, 1, 16'hA5A5, 16'h0000, 1, 0, 0);
      vecs[8]  = mkV(1, 16'h0020, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0, 16'h0200, 16'h1234, 0, 0, 16'hA5A5, 16'h0000, 1, 0, 0);
      vecs[9]  = mkV(1, 16'h0020, 0, 0, 16'h0000, 16'h0000, 1, 16'h1111, 1, 0, 16'h0020, 16'h0000, 0, 0, 16'hA5A5, 16'h0000, 1, 0, 0);
      vecs[10] = mkV(1, 16'h0020, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0, 16'h0020, 16'h0000, 1, 0, 16'h1111, 16'h0000, 0, 0, 0);
      vecs[11] = mkV(0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0, 16'h0020, 16'h0000, 0, 0, 16'h1111, 16'h0000, 0, 0, 0);

      rst = 1'b0; if_req = 1'b0; if_addr = '0; d_en = 1'b0; d_wr = 1'b0;
      d_addr = '0; d_wdata = '0; memDoneDrv = 1'b0; mem_rdata = '0; autoResp = 1'b0;
      #2 rst = 1'b1;
      tick();
      tick();
      chk1 ("reset mem_rd", mem_rd, 1'b0);
      chk1 ("reset mem_wr", mem_wr, 1'b0);
      chk16("reset mem_addr", mem_addr, 16'h0000);
      chk1 ("reset if_done", if_done, 1'b0);
      chk1 ("reset d_done", d_done, 1'b0);
      chk16("reset d_rdata", d_rdata, 16'h0000);
      chk1 ("reset err", err, 1'b0);
      rst = 1'b0;

      // ---------------- table-driven cycles ----------------
      for (int i = 0; i < c_NVEC; i++) begin
         if_req     = vecs[i].ifReq;
         if_addr    = vecs[i].ifAddr;
         d_en       = vecs[i].dEn;
         d_wr       = vecs[i].dWr;
         d_addr     = vecs[i].dAddr;
         d_wdata    = vecs[i].dWdata;
         memDoneDrv = vecs[i].memDone;
         mem_rdata  = vecs[i].memRdata;
         #1;
         chk1 ($sformatf("vec%0d mem_rd", i),    mem_rd,    vecs[i].eMemRd);
         chk1 ($sformatf("vec%0d mem_wr", i),    mem_wr,    vecs[i].eMemWr);
         chk16($sformatf("vec%0d mem_addr", i),  mem_addr,  vecs[i].eMemAddr);
         chk16($sformatf("vec%0d mem_wdata", i), mem_wdata, vecs[i].eMemWdata);
         chk1 ($sformatf("vec%0d if_done", i),   if_done,   vecs[i].eIfDone);
         chk1 ($sformatf("vec%0d d_done", i),    d_done,    vecs[i].eDDone);
         chk16($sformatf("vec%0d if_rdata", i),  if_rdata,  vecs[i].eIfRdata);
         chk16($sformatf("vec%0d d_rdata", i),   d_rdata,   vecs[i].eDRdata);
         chk1 ($sformatf("vec%0d if_stall", i),  if_stall,  vecs[i].eIfStall);
         chk1 ($sformatf("vec%0d d_stall", i),   d_stall,   vecs[i].eDStall);
         chk1 ($sformatf("vec%0d err", i),       err,       vecs[i].eErr);
         tick();
      end
      memDoneDrv = 1'b0; if_req = 1'b0; d_en = 1'b0;

      // ---------------- fairness: fetch waits behind 3 data grants ----------------
      autoResp = 1'b1;
      mem_rdata = 16'h7777;
      if_req = 1'b1; if_addr = 16'h0040;
      d_en = 1'b1; d_wr = 1'b0; d_addr = 16'h0100;
      nGrant = 0; nDDone = 0;
      for (int cyc = 0; cyc < 60 && (d_en || if_req); cyc++) begin
         #1;
         if (mem_rd && nGrant < 8) begin
            grantLog[nGrant] = mem_addr;
            nGrant++;
         end
         if (if_done) if_req = 1'b0;
         if (d_done) begin
            nDDone++;
            if (nDDone == 4) d_en = 1'b0;
         end
         tick();
      end
      autoResp = 1'b0;
      chk16("fair grant count", 16'(nGrant), 16'd5);
      chk16("fair grant0", grantLog[0], 16'h0100);
      chk16("fair grant1", grantLog[1], 16'h0100);
      chk16("fair grant2", grantLog[2], 16'h0100);
      chk16("fair grant3", grantLog[3], 16'h0040);
      chk16("fair grant4", grantLog[4], 16'h0100);
      chk16("fair if_rdata", if_rdata, 16'h7777);
      chk16("fair d_rdata", d_rdata, 16'h7777);
      tick();

      // ---------------- load that never completes ----------------
      d_en = 1'b1; d_wr = 1'b0; d_addr = 16'h0300;
      tick();
      busy = 0;
      while (mem_rd && busy < 40) begin
         busy++;
         tick();
      end
      chk16("timeout busy cycles", 16'(busy), 16'd15);
      chk1 ("timeout err", err, 1'b1);
      chk1 ("timeout d_done", d_done, 1'b0);
      chk1 ("timeout d_stall", d_stall, 1'b1);
      chk1 ("timeout mem_rd", mem_rd, 1'b0);
      chk1 ("timeout mem_wr", mem_wr, 1'b0);
      d_en = 1'b0;
      tick();
      chk1 ("timeout err sticky", err, 1'b1);

      // ---------------- reset abandons an in-flight access ----------------
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk1 ("rst clears err", err, 1'b0);
      d_en = 1'b1; d_wr = 1'b0; d_addr = 16'h0400;
      tick();
      chk1 ("rst pre mem_rd", mem_rd, 1'b1);
      chk16("rst pre mem_addr", mem_addr, 16'h0400);
      #2 rst = 1'b1;
      #1;
      chk1 ("rst mid mem_rd", mem_rd, 1'b0);
      chk16("rst mid mem_addr", mem_addr, 16'h0000);
      chk1 ("rst mid err", err, 1'b0);
      chk1 ("rst mid d_done", d_done, 1'b0);
      memDoneDrv = 1'b1; mem_rdata = 16'h9999; d_en = 1'b0;
      tick();
      rst = 1'b0;
      tick();
      memDoneDrv = 1'b0;
      for (int k = 0; k < 3; k++) begin
         chk1 ($sformatf("rst post%0d d_done", k), d_done, 1'b0);
         chk1 ($sformatf("rst post%0d mem_rd", k), mem_rd, 1'b0);
         chk16($sformatf("rst post%0d d_rdata", k), d_rdata, 16'h0000);
         tick();
      end

      // ---------------- completion on the last allowed busy cycle ----------------
      d_en = 1'b1; d_wr = 1'b0; d_addr = 16'h0500;
      tick();
      busy = 0;
      while (mem_rd && busy < 14) begin
         busy++;
         tick();
      end
      chk16("race busy cycles", 16'(busy), 16'd14);
      chk1 ("race mem_rd", mem_rd, 1'b1);
      memDoneDrv = 1'b1; mem_rdata = 16'h5A5A;
      tick();
      memDoneDrv = 1'b0;
      chk1 ("race d_done", d_done, 1'b1);
      chk16("race d_rdata", d_rdata, 16'h5A5A);
      chk1 ("race err", err, 1'b0);
      d_en = 1'b0;
      tick();
      chk1 ("race err after", err, 1'b0);
      chk1 ("race mem_rd after", mem_rd, 1'b0);
      chk16("race d_rdata hold", d_rdata, 16'h5A5A);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_mem_arbiter
`default_nettype wire
